sram_req_sequencer: RTL and testbench
=====================================

SRAM_REQ_SEQUENCER -- requirements
Module: sram_req_sequencer

Interface
REQ-001 Parameter DIV, default 4, i_clk cycles per o_advance pulse (legal 1..255).
REQ-002 Parameter DEPTH, default 4, request FIFO entries (power of two, 2..16).
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req_valid / o_req_ready / i_req_rd_n_wr / i_req_addr[15:0] / i_req_wdata[7:0]  in/out/in/in/in  application request channel.
REQ-006 o_rsp_valid  out  1 and o_rsp_rdata  out  8  read completion, one-cycle pulse, no backpressure.
REQ-007 o_advance  out  1  SPI-controller advance tick.
REQ-008 o_valid / o_rd_n_wr / o_addr[15:0] / o_wdata[7:0]  out  controller request, held stable for the whole transaction.
REQ-009 i_cs  in  1  controller chip select (high = idle); i_ready  in  1  read-done pulse; i_rdata  in  8  read data, valid in the i_ready cycle.
REQ-010 o_cfg_done  out  1  high once the controller's post-reset configuration sequence has completed.

Function
REQ-011 Divider counter runs 0..DIV-1 from reset release; o_advance=1 in the cycle the count equals DIV-1; with DIV=1, o_advance is constantly 1.
REQ-012 FIFO: o_req_ready = ~full; push on i_req_valid & o_req_ready; pop only on the FSM IDLE->ISSUE transition; a push and pop in the same cycle leave the occupancy unchanged.
REQ-013 FSM states: IDLE, ISSUE, BUSY.
REQ-014 IDLE: when the FIFO is not empty, pop the head into the hold register and go to ISSUE.
REQ-015 ISSUE: o_valid=1; on i_cs==0 deassert o_valid and go to BUSY.
REQ-016 BUSY: o_valid=0; o_addr/o_wdata/o_rd_n_wr are held; on i_cs returning to 1, go to IDLE, except as REQ-017.
REQ-017 If o_cfg_done==0, the first i_cs low->high excursion is the configuration sequence: set o_cfg_done=1 and return to ISSUE with the same held request (re-issue, no pop).
REQ-018 o_rsp_valid=1 with o_rsp_rdata=i_rdata in the cycle i_ready=1 while BUSY with a read held; i_ready is ignored in every other state.
REQ-019 Writes produce no response; write completion is the i_cs rise in BUSY.
REQ-020 At most one transaction outstanding; FIFO ordering strict.
REQ-021 o_addr/o_wdata/o_rd_n_wr change only on the IDLE->ISSUE transition.

Reset
REQ-022 On i_rst: FSM=IDLE, FIFO empty, divider=0, o_cfg_done=0, o_valid=0, o_rsp_valid=0, o_rsp_rdata=0, hold register=0, o_advance=0 (1 when DIV=1), o_req_ready=1.
REQ-023 Reset mid-transaction discards the held and queued requests; no response is emitted for them.

Structure
REQ-024 Shared package x_23k640_pkg holds the request struct typedef (rd_n_wr, addr, wdata), the FSM state enum, and the DIV/DEPTH defaults.
REQ-025 FIFO is one sub-module, sram_req_fifo (parameter DEPTH, struct payload, count-based full/empty); the divider and FSM stay inline.

Verification
REQ-026 DIV=4, idle -> o_advance pulses exactly at cycles 3, 7, 11 after reset release.
REQ-027 First read 0x1234 after reset, model performs config then read returning 0xA5 -> exactly one request re-issue, o_cfg_done=1, one o_rsp_valid with 0xA5.
REQ-028 Write 0x0010/0x5A then read 0x0010 -> o_addr/o_wdata stable through each BUSY period, read response 0x5A, no response for the write.
REQ-029 DEPTH=4, 6 back-to-back requests while busy -> o_req_ready low after 4 accepted (5 if one popped), in-order issue, no loss.
REQ-030 i_rst asserted during BUSY of a read -> all outputs at reset values next cycle, no o_rsp_valid, o_cfg_done=0.
REQ-031 Spurious i_ready during IDLE or a write -> no o_rsp_valid.

Source files
------------

// File: rtl/x_23k640_pkg.sv
// Shared types and defaults for the SRAM request sequencer and its FIFO.
package x_23k640_pkg;

  localparam int unsigned DivDefault   = 4;
  localparam int unsigned DepthDefault = 4;

  typedef struct packed {
    logic        rd_n_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy
  } state_e;

endpackage

// File: rtl/sram_req_fifo.sv
// Count-based request FIFO; DEPTH must be a power of two so pointers wrap freely.
module sram_req_fifo
  import x_23k640_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = DEPTH[PtrW:0];
  localparam logic [PtrW:0] CntOne = 1;
  localparam logic [PtrW-1:0] PtrOne = 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  req_t            mem_q [DEPTH];
  logic            push_en, pop_en;

  assign o_full  = (count_q == CntFull);
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_ptr_q];
  assign push_en = i_push & ~o_full;
  assign pop_en  = i_pop & ~o_empty;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/sram_req_sequencer.sv
// Sequences application SRAM requests onto a single-outstanding SPI controller,
// replaying the first request after reset behind the controller's config sequence.
module sram_req_sequencer
  import x_23k640_pkg::*;
#(
  parameter int unsigned DIV   = DivDefault,
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rd_n_wr,
  input  logic [15:0] i_req_addr,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_advance,
  output logic        o_valid,
  output logic        o_rd_n_wr,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  input  logic        i_cs,
  input  logic        i_ready,
  input  logic [7:0]  i_rdata,
  output logic        o_cfg_done
);

  localparam logic [7:0] DivLast = 8'(DIV - 1);

  logic [7:0] div_cnt_q;
  state_e     state_q, state_d;
  req_t       hold_q, hold_d;
  logic       cfg_done_q, cfg_done_d;
  logic       fifo_full, fifo_empty, fifo_pop;
  req_t       fifo_head, req_in;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DivLast) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

  assign o_advance = (div_cnt_q == DivLast);

  assign req_in = '{rd_n_wr: i_req_rd_n_wr, addr: i_req_addr, wdata: i_req_wdata};

  sram_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req_valid),
    .i_data  (req_in),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_req_ready = ~fifo_full;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cfg_done_d = cfg_done_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (!i_cs) state_d = StBusy;
      end
      StBusy: begin
        if (i_cs) begin
          // The first chip-select excursion was the controller's own config
          // sequence, so the held request still has to be sent.
          if (!cfg_done_q) begin
            cfg_done_d = 1'b1;
            state_d    = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign o_valid     = (state_q == StIssue);
  assign o_rd_n_wr   = hold_q.rd_n_wr;
  assign o_addr      = hold_q.addr;
  assign o_wdata     = hold_q.wdata;
  assign o_cfg_done  = cfg_done_q;
  assign o_rsp_valid = (state_q == StBusy) & hold_q.rd_n_wr & i_ready;
  assign o_rsp_rdata = o_rsp_valid ? i_rdata : 8'h00;

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Randomized bench for sram_req_sequencer: a behavioural SPI-controller model
// drives the DUT while an in-order scoreboard predicts issues and read data.
module tb_sram_req_sequencer;
  import x_23k640_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_rd_n_wr = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        req_ready, rsp_valid, advance, valid, rd_n_wr, cfg_done;
  logic [7:0]  rsp_rdata, wdata;
  logic [15:0] addr;

  logic        ctl_cs = 1'b1, ctl_ready = 1'b0, spur_ready = 1'b0;
  logic        ctl_stall = 1'b0, ctl_cfg_seen = 1'b0;
  logic [7:0]  ctl_rdata = 8'h0;
  logic        ready_in;
  logic [7:0]  rdata_in;
  int          ctl_phase = 0;

  assign ready_in = ctl_ready | spur_ready;
  assign rdata_in = spur_ready ? 8'hEE : ctl_rdata;

  int         vectors = 0, miscompares = 0, issue_cnt = 0, rsp_cnt = 0;
  logic [7:0] last_rsp = 8'h0;
  logic [7:0] ref_mem [65536];
  logic [7:0] ctl_mem [65536];
  req_t       exp_issue [$];
  logic [7:0] exp_rsp [$];
  bit         first_since_reset = 1'b1;

  sram_req_sequencer #(
    .DIV   (4),
    .DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_rd_n_wr (req_rd_n_wr),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rdata   (rsp_rdata),
    .o_advance     (advance),
    .o_valid       (valid),
    .o_rd_n_wr     (rd_n_wr),
    .o_addr        (addr),
    .o_wdata       (wdata),
    .i_cs          (ctl_cs),
    .i_ready       (ready_in),
    .i_rdata       (rdata_in),
    .o_cfg_done    (cfg_done)
  );

  // Controller model: first excursion after reset is its config sequence.
  initial begin
    req_t cur;
    int   delay;
    int   hold;
    cur = '0;
    delay = 0;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ctl_cs = 1'b1; ctl_ready = 1'b0; ctl_phase = 0; ctl_cfg_seen = 1'b0;
      end else begin
        case (ctl_phase)
          0: if (valid) begin delay = $urandom_range(0, 2); ctl_phase = 1; end
          1: begin
            if (delay == 0) begin
              ctl_cs = 1'b0;
              cur = {rd_n_wr, addr, wdata};
              hold = $urandom_range(1, 3);
              ctl_phase = 2;
            end else begin
              delay--;
            end
          end
          2: begin
            if (!ctl_stall) begin
              if (hold > 0) begin
                hold--;
              end else begin
                if (ctl_cfg_seen && cur.rd_n_wr) begin
                  ctl_ready = 1'b1;
                  ctl_rdata = ctl_mem[cur.addr];
                end
                ctl_phase = 3;
              end
            end
          end
          3: begin
            ctl_ready = 1'b0;
            if (ctl_cfg_seen && !cur.rd_n_wr) ctl_mem[cur.addr] = cur.wdata;
            ctl_cs = 1'b1;
            ctl_cfg_seen = 1'b1;
            ctl_phase = 0;
          end
          default: ctl_phase = 0;
        endcase
      end
    end
  end

  // Issue order and hold stability across each transaction.
  initial begin
    bit   vprev, active, cs_low, unstable;
    req_t cap, exp;
    vprev = 0; active = 0; cs_low = 0; unstable = 0; cap = '0; exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        vprev = 0; active = 0;
      end else begin
        if (valid && !vprev) begin
          issue_cnt++;
          vectors++;
          if (exp_issue.size() == 0) begin
            miscompares++;
            $display("FAIL issue_unexpected: got rd=%b addr=%h wdata=%h, required no issue",
                     rd_n_wr, addr, wdata);
          end else begin
            exp = exp_issue.pop_front();
            if ({rd_n_wr, addr, wdata} !== exp) begin
              miscompares++;
              $display("FAIL issue_order: got rd=%b addr=%h wdata=%h, required rd=%b addr=%h wdata=%h",
                       rd_n_wr, addr, wdata, exp.rd_n_wr, exp.addr, exp.wdata);
            end
          end
          cap = {rd_n_wr, addr, wdata};
          active = 1; cs_low = 0; unstable = 0;
        end else if (active) begin
          if ({rd_n_wr, addr, wdata} !== cap) unstable = 1;
          if (!ctl_cs) cs_low = 1;
          if (cs_low && ctl_cs) begin
            vectors++;
            if (unstable !== 1'b0) begin
              miscompares++;
              $display("FAIL hold_stable: got request change during transaction, required stable %h",
                       cap);
            end
            active = 0;
          end
        end
        vprev = valid;
      end
    end
  end

  // Read responses against the scoreboard.
  initial begin
    logic [7:0] exp;
    exp = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        rsp_cnt++;
        last_rsp = rsp_rdata;
        vectors++;
        if (exp_rsp.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got rdata=%h, required no response", rsp_rdata);
        end else begin
          exp = exp_rsp.pop_front();
          if (rsp_rdata !== exp) begin
            miscompares++;
            $display("FAIL rsp_data: got %h, required %h", rsp_rdata, exp);
          end
        end
      end
    end
  end

  task automatic model_accept(input logic rd, input logic [15:0] a, input logic [7:0] d);
    exp_issue.push_back({rd, a, d});
    if (first_since_reset) begin
      exp_issue.push_back({rd, a, d});
      first_since_reset = 1'b0;
    end
    if (rd) exp_rsp.push_back(ref_mem[a]);
    else    ref_mem[a] = d;
  endtask

  // Call at a negedge; returns at a negedge with req_valid low.
  task automatic push_req(input logic rd, input logic [15:0] a, input logic [7:0] d);
    int budget = 400;
    req_valid = 1'b1; req_rd_n_wr = rd; req_addr = a; req_wdata = d;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_timeout: got ready=%b, required 1 within budget", req_ready);
    end else begin
      model_accept(rd, a, d);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 2000;
    while (budget > 0 && !(exp_issue.size() == 0 && exp_rsp.size() == 0 && ctl_phase == 0
                           && ctl_cs && !valid)) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (budget == 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d issues %0d rsps pending, required 0",
               exp_issue.size(), exp_rsp.size());
    end
  endtask

  task automatic wait_busy();
    int budget = 200;
    while (ctl_cs && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (ctl_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_timeout: got cs=%b, required 0", ctl_cs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 3;
    if ({valid, rsp_valid, cfg_done, advance, rd_n_wr} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 00000",
               {valid, rsp_valid, cfg_done, advance, rd_n_wr});
    end
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    if ({addr, wdata, rsp_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 0", {addr, wdata, rsp_rdata});
    end
  endtask

  task automatic test_divider();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (advance !== ((k % 4) == 3)) begin
        miscompares++;
        $display("FAIL advance_cycle%0d: got %b, required %b", k, advance, (k % 4) == 3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cfg_read();
    int i0 = issue_cnt, r0 = rsp_cnt;
    push_req(1'b1, 16'h1234, 8'h00);
    wait_drain();
    vectors += 3;
    if (issue_cnt - i0 !== 2) begin
      miscompares++;
      $display("FAIL cfg_reissue: got %0d issues, required 2", issue_cnt - i0);
    end
    if (cfg_done !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_done: got %b, required 1", cfg_done);
    end
    if (rsp_cnt - r0 !== 1 || last_rsp !== 8'hA5) begin
      miscompares++;
      $display("FAIL cfg_read_rsp: got %0d rsp data %h, required 1 rsp data a5",
               rsp_cnt - r0, last_rsp);
    end
  endtask

  task automatic test_write_read();
    int i0 = issue_cnt, r0 = rsp_cnt;
    push_req(1'b0, 16'h0010, 8'h5A);
    push_req(1'b1, 16'h0010, 8'h00);
    wait_drain();
    vectors += 2;
    if (issue_cnt - i0 !== 2) begin
      miscompares++;
      $display("FAIL wr_rd_issues: got %0d, required 2", issue_cnt - i0);
    end
    if (rsp_cnt - r0 !== 1 || last_rsp !== 8'h5A) begin
      miscompares++;
      $display("FAIL wr_rd_rsp: got %0d rsp data %h, required 1 rsp data 5a",
               rsp_cnt - r0, last_rsp);
    end
  endtask

  task automatic test_spurious();
    int r0 = rsp_cnt;
    @(posedge clk); #1 spur_ready = 1'b1;
    @(posedge clk); #1 spur_ready = 1'b0;
    @(negedge clk);
    push_req(1'b0, 16'h0003, 8'h77);
    wait_busy();
    @(posedge clk); #1 spur_ready = 1'b1;
    @(posedge clk); #1 spur_ready = 1'b0;
    @(negedge clk);
    wait_drain();
    vectors++;
    if (rsp_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL spurious_ready: got %0d responses, required 0", rsp_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    req_t reqs [6];
    int   i0 = issue_cnt, r0 = rsp_cnt, reads = 0, idx = 0, acc_at_stall = -1, budget = 500;
    for (int k = 0; k < 6; k++) begin
      reqs[k] = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom)};
      if (reqs[k].rd_n_wr) reads++;
    end
    ctl_stall = 1'b1;
    push_req(1'b0, 16'h0008, 8'h11);
    wait_busy();
    while (idx < 6 && budget > 0) begin
      req_valid = 1'b1;
      {req_rd_n_wr, req_addr, req_wdata} = reqs[idx];
      if (req_ready) begin
        model_accept(reqs[idx].rd_n_wr, reqs[idx].addr, reqs[idx].wdata);
        idx++;
      end else if (acc_at_stall < 0) begin
        acc_at_stall = idx;
        ctl_stall = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    req_valid = 1'b0;
    ctl_stall = 1'b0;
    wait_drain();
    vectors += 3;
    if (acc_at_stall !== 4) begin
      miscompares++;
      $display("FAIL full_at: got ready low after %0d accepts, required 4", acc_at_stall);
    end
    if (issue_cnt - i0 !== 7) begin
      miscompares++;
      $display("FAIL b2b_issues: got %0d, required 7", issue_cnt - i0);
    end
    if (rsp_cnt - r0 !== reads) begin
      miscompares++;
      $display("FAIL b2b_rsps: got %0d, required %0d", rsp_cnt - r0, reads);
    end
  endtask

  task automatic test_random();
    int i0 = issue_cnt, r0 = rsp_cnt, reads = 0;
    logic rd;
    for (int k = 0; k < 20; k++) begin
      rd = 1'($urandom_range(0, 1));
      if (rd) reads++;
      push_req(rd, 16'($urandom_range(0, 15)), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    vectors += 2;
    if (issue_cnt - i0 !== 20) begin
      miscompares++;
      $display("FAIL rand_issues: got %0d, required 20", issue_cnt - i0);
    end
    if (rsp_cnt - r0 !== reads) begin
      miscompares++;
      $display("FAIL rand_rsps: got %0d, required %0d", rsp_cnt - r0, reads);
    end
  endtask

  task automatic test_reset_mid();
    int i0, r0;
    ctl_stall = 1'b1;
    push_req(1'b1, 16'h0005, 8'h00);
    push_req(1'b1, 16'h0006, 8'h00);
    wait_busy();
    rst = 1'b1;
    exp_issue.delete();
    exp_rsp.delete();
    first_since_reset = 1'b1;
    ctl_stall = 1'b0;
    @(negedge clk);
    vectors += 3;
    if ({valid, rsp_valid, cfg_done, advance} !== 4'b0) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b, required 0000", {valid, rsp_valid, cfg_done, advance});
    end
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b, required 1", req_ready);
    end
    if ({addr, wdata, rsp_rdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_data: got %h, required 0", {addr, wdata, rsp_rdata});
    end
    @(negedge clk);
    rst = 1'b0;
    i0 = issue_cnt;
    r0 = rsp_cnt;
    repeat (30) @(negedge clk);
    vectors++;
    if (issue_cnt - i0 !== 0 || rsp_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL midrst_discard: got %0d issues %0d rsps, required 0 0",
               issue_cnt - i0, rsp_cnt - r0);
    end
    push_req(1'b1, 16'h1234, 8'h00);
    wait_drain();
    vectors++;
    if (issue_cnt - i0 !== 2 || cfg_done !== 1'b1 || last_rsp !== 8'hA5) begin
      miscompares++;
      $display("FAIL midrst_recfg: got %0d issues cfg=%b data %h, required 2 1 a5",
               issue_cnt - i0, cfg_done, last_rsp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 8'(i ^ (i >> 8));
      ctl_mem[i] = ref_mem[i];
    end
    ref_mem[16'h1234] = 8'hA5;
    ctl_mem[16'h1234] = 8'hA5;
    @(negedge clk);
    test_reset();
    test_divider();
    test_cfg_read();
    test_write_read();
    test_spurious();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
